// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller and ALU decoder: sequences fetch/decode/execute/mem/writeback
// over a shared memory port and decodes every datapath enable and mux select.
module multicycle_ctrl #(
   parameter int MEM_WAIT_MAX = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLE   = 6'b000110;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;

   state_t        cur, nxt;
   logic [CW-1:0] wait_cnt;
   logic          waiting;
   logic          pcen_raw, irwrite_raw, regwrite_raw, memwrite_raw, illegal_raw;
   logic          funct_ok;

   assign funct_ok = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                     (funct == 6'b100101) || (funct == 6'b101010) || (funct == 6'b000000);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur         <= FETCH;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         cur <= nxt;
         // Any state change clears the wait counter; it only counts while parked on memory.
         if (nxt != cur) begin
            wait_cnt <= '0;
         end else if (waiting && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_MAX - 1'b1) mem_timeout <= 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      nxt          = cur;
      iord         = 1'b0;
      memwrite_raw = 1'b0;
      irwrite_raw  = 1'b0;
      pcen_raw     = 1'b0;
      regwrite_raw = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      alucontrol   = 3'b000;
      illegal_raw  = 1'b0;
      waiting      = 1'b0;
      unique case (cur)
         FETCH: begin
            alusrcb     = 2'b01;
            alucontrol  = 3'b010;
            irwrite_raw = mem_ready;
            pcen_raw    = mem_ready;
            waiting     = !mem_ready;
            if (mem_ready) nxt = DECODE;
         end
         DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = 3'b010;
            case (op)
               OP_LW, OP_SW:   nxt = MEMADR;
               OP_BEQ, OP_BLE: nxt = BRANCH;
               OP_ADDI:        nxt = ADDIEX;
               OP_J:           nxt = JUMP;
               OP_RTYPE: begin
                  if (funct_ok) nxt = EXECUTE;
                  else begin
                     illegal_raw = 1'b1;
                     nxt         = FETCH;
                  end
               end
               default: begin
                  illegal_raw = 1'b1;
                  nxt         = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b010;
            nxt        = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord    = 1'b1;
            waiting = !mem_ready;
            if (mem_ready) nxt = MEMWB;
         end
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
            nxt          = FETCH;
         end
         MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
            waiting      = !mem_ready;
            if (mem_ready) nxt = FETCH;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               6'b000000: alucontrol = 3'b011;
               default:   alucontrol = 3'b010;
            endcase
            nxt = ALUWB;
         end
         ALUWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
            nxt          = FETCH;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            pcen_raw   = (op == OP_BLE) ? (zero | sign) : zero;
            nxt        = FETCH;
         end
         ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b010;
            nxt        = ADDIWB;
         end
         ADDIWB: begin
            regwrite_raw = 1'b1;
            nxt          = FETCH;
         end
         JUMP: begin
            pcsrc    = 2'b10;
            pcen_raw = 1'b1;
            nxt      = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

   // Strobes are suppressed while reset is held so an aborted access leaves no side effects.
   assign pcen       = pcen_raw     & ~reset;
   assign irwrite    = irwrite_raw  & ~reset;
   assign regwrite   = regwrite_raw & ~reset;
   assign memwrite   = memwrite_raw & ~reset;
   assign illegal_op = illegal_raw  & ~reset;
   assign state      = cur;

endmodule
